// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Memory-stage load/store unit. Decodes size/sign from funct3M,
//            checks alignment, builds byte enables and lane-replicated store
//            data, runs a request/grant bus transaction and returns the
//            sign/zero-extended load result in the cycle the stall drops.
// Optional : LSU_TIMEOUT_EN - adds a REQ/WAIT watchdog that terminates a
//            stuck access after TIMEOUT_CYCLES cycles and flags BusErrM.
// Ports    : clk, reset (sync, active-high)
//            MemReadM/MemWriteM/funct3M/Mem_WrAddr/Mem_WrData - M-stage access
//            ReadData  - extended load data, non-zero only in the DONE cycle
//            StallLSU  - pipeline hold while the access is outstanding
//            MisalignM - misaligned address or reserved funct3M
//            BusErrM   - watchdog expiry (0 without LSU_TIMEOUT_EN)
//            bus_*     - word-wide request/grant data bus
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    output logic [31:0] ReadData,
    output logic        StallLSU,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    logic [1:0]  r_state;
    logic        r_bus_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic [31:0] r_rdata;
    logic        r_buserr;

    logic        w_access;
    logic        w_store;
    logic        w_idle;
    logic        w_fault;
    logic        w_accept;
    logic [1:0]  w_off;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_ext;

`ifdef LSU_TIMEOUT_EN
    localparam int c_WDOG_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [c_WDOG_W-1:0] c_WDOG_LIMIT = c_WDOG_W'(TIMEOUT_CYCLES);

    logic [c_WDOG_W-1:0] r_wdog;
    logic [c_WDOG_W-1:0] w_wdog_nxt;
    logic                w_wdog_hit;

    assign w_wdog_nxt = r_wdog + 1'b1;
    // >= rather than == so a grant landing on the limit cycle cannot let the
    // counter run past the limit and disarm the watchdog for the WAIT phase.
    assign w_wdog_hit = (w_wdog_nxt >= c_WDOG_LIMIT);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // A simultaneous load+store request is treated as a store.
    assign w_access = MemReadM | MemWriteM;
    assign w_store  = MemWriteM;
    assign w_off    = Mem_WrAddr[1:0];
    assign w_idle   = (r_state == c_ST_IDLE);

    // Size decode: fault detection, byte enables and store lane replication.
    always_comb begin
        w_fault = 1'b0;
        w_be    = 4'b0000;
        w_wdata = Mem_WrData;
        case (funct3M)
            3'b000: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{Mem_WrData[7:0]}};
            end
            3'b001: begin
                w_fault = w_off[0];
                w_be    = 4'b0011 << {w_off[1], 1'b0};
                w_wdata = {2{Mem_WrData[15:0]}};
            end
            3'b010: begin
                w_fault = |w_off;
                w_be    = 4'b1111;
            end
            3'b100: begin
                w_fault = w_store;
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{Mem_WrData[7:0]}};
            end
            3'b101: begin
                w_fault = w_store | w_off[0];
                w_be    = 4'b0011 << {w_off[1], 1'b0};
                w_wdata = {2{Mem_WrData[15:0]}};
            end
            default: begin
                w_fault = 1'b1;
            end
        endcase
    end

    assign w_accept = w_idle & w_access & ~w_fault;

    // Status outputs are forced low while reset is held.
    assign MisalignM = ~reset & w_idle & w_access & w_fault;
    assign StallLSU  = ~reset & (w_accept | (r_state == c_ST_REQ) | (r_state == c_ST_WAIT));

`ifdef LSU_TIMEOUT_EN
    assign BusErrM = ~reset & (r_state == c_ST_DONE) & r_buserr;
`else
    assign BusErrM = 1'b0;
`endif

    assign bus_req   = r_bus_req;
    assign bus_we    = r_we;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign bus_be    = r_be;

    // Load extraction from the captured word using the offset/size latched
    // at acceptance; the live M-stage inputs may already differ here.
    always_comb begin
        case (r_off)
            2'd0:    w_ld_byte = r_rdata[7:0];
            2'd1:    w_ld_byte = r_rdata[15:8];
            2'd2:    w_ld_byte = r_rdata[23:16];
            default: w_ld_byte = r_rdata[31:24];
        endcase
    end

    assign w_ld_half = r_off[1] ? r_rdata[31:16] : r_rdata[15:0];

    always_comb begin
        w_ld_ext = r_rdata;
        case (r_f3[1:0])
            2'b00:   w_ld_ext = {{24{w_ld_byte[7] & ~r_f3[2]}}, w_ld_byte};
            2'b01:   w_ld_ext = {{16{w_ld_half[15] & ~r_f3[2]}}, w_ld_half};
            default: w_ld_ext = r_rdata;
        endcase
    end

    assign ReadData = (~reset && (r_state == c_ST_DONE) && !r_we && !r_buserr) ? w_ld_ext : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_bus_req <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_be      <= 4'b0000;
            r_f3      <= 3'b000;
            r_off     <= 2'b00;
            r_rdata   <= 32'd0;
            r_buserr  <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            r_wdog    <= '0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_state   <= c_ST_REQ;
                        r_bus_req <= 1'b1;
                        r_we      <= w_store;
                        r_addr    <= {Mem_WrAddr[31:2], 2'b00};
                        r_wdata   <= w_wdata;
                        r_be      <= w_be;
                        r_f3      <= funct3M;
                        r_off     <= w_off;
                        r_buserr  <= 1'b0;
`ifdef LSU_TIMEOUT_EN
                        r_wdog    <= '0;
`endif
                    end
                end
                c_ST_REQ: begin
`ifdef LSU_TIMEOUT_EN
                    r_wdog <= w_wdog_nxt;
`endif
                    if (bus_gnt) begin
                        r_bus_req <= 1'b0;
                        r_state   <= r_we ? c_ST_DONE : c_ST_WAIT;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (w_wdog_hit) begin
                        r_bus_req <= 1'b0;
                        r_buserr  <= 1'b1;
                        r_state   <= c_ST_DONE;
                    end
`endif
                end
                c_ST_WAIT: begin
`ifdef LSU_TIMEOUT_EN
                    r_wdog <= w_wdog_nxt;
`endif
                    if (bus_rvalid) begin
                        r_rdata <= bus_rdata;
                        r_state <= c_ST_DONE;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (w_wdog_hit) begin
                        r_buserr <= 1'b1;
                        r_state  <= c_ST_DONE;
                    end
`endif
                end
                default: begin
                    r_state  <= c_ST_IDLE;
                    r_buserr <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit. A transaction-level
//            model derives per-cycle expectations from the access rules and
//            latency budget; a single compare process checks them each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

`ifdef LSU_TIMEOUT_EN
    localparam int c_TO    = 4;
    localparam int c_MAX_G = 1;
    localparam int c_MAX_R = 0;
`else
    localparam int c_TO    = 255;
    localparam int c_MAX_G = 5;
    localparam int c_MAX_R = 3;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] Mem_WrAddr, Mem_WrData;
    logic [31:0] ReadData;
    logic        StallLSU, MisalignM, BusErrM;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(c_TO)) dut (
        .clk(clk), .reset(reset),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
        .Mem_WrAddr(Mem_WrAddr), .Mem_WrData(Mem_WrData),
        .ReadData(ReadData), .StallLSU(StallLSU), .MisalignM(MisalignM), .BusErrM(BusErrM),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Per-cycle expectations written by the driver, read by the compare process.
    logic        chk_en = 1'b0;
    logic        e_stall, e_mis, e_buserr, e_req, e_req_chk, e_bus_chk, e_wd_chk, e_rd_chk, e_we;
    logic [31:0] e_rd, e_addr, e_wdata;
    logic [3:0]  e_be;

    // Observations for the literal pins.
    int          stall_run = 0;
    int          last_stall_run = 0;
    logic [31:0] obs_addr = 32'd0, obs_wdata = 32'd0, obs_rd = 32'd0;
    logic [3:0]  obs_be = 4'd0;
    logic        obs_mis = 1'b0, obs_buserr = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("StallLSU",  {31'd0, StallLSU},  {31'd0, e_stall});
            check("MisalignM", {31'd0, MisalignM}, {31'd0, e_mis});
            check("BusErrM",   {31'd0, BusErrM},   {31'd0, e_buserr});
            if (e_req_chk) check("bus_req", {31'd0, bus_req}, {31'd0, e_req});
            if (e_bus_chk) begin
                check("bus_addr", bus_addr, e_addr);
                check("bus_we",   {31'd0, bus_we}, {31'd0, e_we});
                check("bus_be",   {28'd0, bus_be}, {28'd0, e_be});
            end
            if (e_wd_chk) check("bus_wdata", bus_wdata, e_wdata);
            if (e_rd_chk) check("ReadData", ReadData, e_rd);
            if (StallLSU) stall_run++;
            else begin
                if (stall_run != 0) last_stall_run = stall_run;
                stall_run = 0;
            end
            if (bus_req) begin
                obs_addr  = bus_addr;
                obs_be    = bus_be;
                obs_wdata = bus_wdata;
            end
            obs_rd     = ReadData;
            obs_mis    = MisalignM;
            obs_buserr = BusErrM;
        end
    end

    // ---------------- behavioural model ----------------
    function automatic bit m_fault(bit st, logic [2:0] f3, logic [1:0] a);
        case (f3)
            3'd0:    return 1'b0;
            3'd1:    return a[0];
            3'd2:    return a != 2'd0;
            3'd4:    return st;
            3'd5:    return st || a[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic int m_nbytes(logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [3:0] m_be(logic [2:0] f3, logic [1:0] a);
        int nb;
        int m;
        nb = m_nbytes(f3);
        m  = ((1 << nb) - 1) << int'(a);
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] d);
        logic [31:0] r;
        int nb;
        nb = m_nbytes(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(logic [2:0] f3, logic [1:0] a, logic [31:0] w);
        int nb;
        logic [31:0] v;
        logic [31:0] mask;
        nb   = m_nbytes(f3);
        v    = w >> (8 * int'(a));
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        v    = v & mask;
        if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- drivers ----------------
    task automatic idle_cycle(bit after_rst, bit rv);
        @(posedge clk); #1;
        reset = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0;
        funct3M = 3'($urandom); Mem_WrAddr = $urandom; Mem_WrData = $urandom;
        bus_gnt = 1'b0; bus_rvalid = rv; bus_rdata = $urandom;
        e_stall = 1'b0; e_mis = 1'b0; e_buserr = 1'b0;
        e_req_chk = 1'b1; e_req = 1'b0; e_rd_chk = 1'b1; e_rd = 32'd0;
        e_bus_chk = after_rst; e_wd_chk = after_rst;
        e_addr = 32'd0; e_we = 1'b0; e_be = 4'd0; e_wdata = 32'd0;
    endtask

    // g: extra REQ cycles before grant; r: extra WAIT cycles before rvalid.
    // rst_at: cycle index (0 = acceptance cycle) at which reset is pulsed, -1 none.
    task automatic do_txn(bit rd, bit wr, logic [2:0] f3, logic [31:0] addr, logic [31:0] data,
                          int g, int r, logic [31:0] rword, int rst_at);
        bit st, acc, flt;
        int n;
        logic [31:0] ld;
        st  = wr;
        acc = rd | wr;
        flt = acc && m_fault(st, f3, addr[1:0]);
        ld  = m_load(f3, addr[1:0], rword);
        if (!acc || flt) begin
            @(posedge clk); #1;
            reset = 1'b0; MemReadM = rd; MemWriteM = wr; funct3M = f3;
            Mem_WrAddr = addr; Mem_WrData = data;
            bus_gnt = 1'b0; bus_rvalid = 1'($urandom); bus_rdata = $urandom;
            e_stall = 1'b0; e_mis = flt; e_buserr = 1'b0;
            e_req_chk = 1'b1; e_req = 1'b0; e_bus_chk = 1'b0; e_wd_chk = 1'b0;
            e_rd_chk = 1'b1; e_rd = 32'd0;
            return;
        end
        n = st ? g + 3 : g + r + 4;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            reset = 1'b0; MemReadM = rd; MemWriteM = wr; funct3M = f3;
            Mem_WrAddr = addr; Mem_WrData = data;
            bus_gnt = (k == g + 1);
            if (!st && k == g + 2 + r)           bus_rvalid = 1'b1;
            else if (!st && k >= g + 2 && k < n - 1) bus_rvalid = 1'b0;
            else                                  bus_rvalid = 1'($urandom);
            bus_rdata = (!st && k == g + 2 + r) ? rword : $urandom;
            e_stall   = (k < n - 1);
            e_mis     = 1'b0;
            e_buserr  = 1'b0;
            e_req_chk = 1'b1;
            e_req     = (k >= 1 && k <= g + 1);
            e_bus_chk = e_req;
            e_wd_chk  = e_req && st;
            e_addr    = {addr[31:2], 2'b00};
            e_we      = st;
            e_be      = m_be(f3, addr[1:0]);
            e_wdata   = m_wdata(f3, data);
            e_rd_chk  = !(k == n - 1 && st);
            e_rd      = (k == n - 1) ? ld : 32'd0;
            if (k == rst_at) begin
                reset = 1'b1; bus_gnt = 1'b0; bus_rvalid = 1'b0;
                e_stall = 1'b0; e_mis = 1'b0; e_buserr = 1'b0;
                e_req_chk = 1'b0; e_bus_chk = 1'b0; e_wd_chk = 1'b0;
                e_rd_chk = 1'b1; e_rd = 32'd0;
                break;
            end
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    // Grant never arrives: c_TO REQ cycles, then a DONE cycle flagging BusErrM.
    task automatic do_timeout(logic [31:0] addr);
        for (int k = 0; k < c_TO + 2; k++) begin
            @(posedge clk); #1;
            reset = 1'b0; MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010;
            Mem_WrAddr = addr; Mem_WrData = $urandom;
            bus_gnt = 1'b0; bus_rvalid = 1'($urandom); bus_rdata = $urandom;
            e_stall = (k <= c_TO); e_mis = 1'b0; e_buserr = (k == c_TO + 1);
            e_req_chk = 1'b1; e_req = (k >= 1 && k <= c_TO);
            e_bus_chk = e_req; e_wd_chk = 1'b0;
            e_addr = addr; e_we = 1'b0; e_be = 4'hF; e_wdata = 32'd0;
            e_rd_chk = 1'b1; e_rd = 32'd0;
        end
    endtask
`endif

    task automatic settle();
        @(negedge clk); #1;
    endtask

    initial begin
        int sel;
        bit rd, wr;
        logic [2:0] f3;
        logic [2:0] valid_f3 [5];
        valid_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        reset = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; funct3M = 3'd0;
        Mem_WrAddr = 32'd0; Mem_WrData = 32'd0;
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk_en = 1'b1;
            e_stall = 1'b0; e_mis = 1'b0; e_buserr = 1'b0;
            e_req_chk = 1'b1; e_req = 1'b0; e_bus_chk = 1'b1; e_wd_chk = 1'b1;
            e_addr = 32'd0; e_we = 1'b0; e_be = 4'd0; e_wdata = 32'd0;
            e_rd_chk = 1'b1; e_rd = 32'd0;
            MemReadM = 1'b1; funct3M = 3'b010;
        end
        idle_cycle(1'b1, 1'b1);

        // sw 0x100
        do_txn(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'd0, -1);
        settle();
        check("sw_be",    {28'd0, obs_be}, 32'h0000_000F);
        check("sw_addr",  obs_addr,  32'h0000_0100);
        check("sw_wdata", obs_wdata, 32'hDEADBEEF);
        check("sw_stall_cycles", last_stall_run, 2);

        // sb 0x103
        do_txn(0, 1, 3'b000, 32'h103, 32'h0000_00A5, 1, 0, 32'd0, -1);
        settle();
        check("sb_be",    {28'd0, obs_be}, 32'h0000_0008);
        check("sb_wdata", obs_wdata, 32'hA5A5_A5A5);
        check("sb_addr",  obs_addr,  32'h0000_0100);

        // loads from 0x102 of 0x1280FF00
        do_txn(1, 0, 3'b000, 32'h102, 32'd0, 0, 0, 32'h1280_FF00, -1);
        settle();
        check("lb_data", obs_rd, 32'hFFFF_FF80);
        check("lb_stall_cycles", last_stall_run, 3);
        do_txn(1, 0, 3'b100, 32'h102, 32'd0, 0, 0, 32'h1280_FF00, -1);
        settle();
        check("lbu_data", obs_rd, 32'h0000_0080);
        do_txn(1, 0, 3'b101, 32'h102, 32'd0, 1, 0, 32'h1280_FF00, -1);
        settle();
        check("lhu_data", obs_rd, 32'h0000_1280);

        // misaligned
        do_txn(1, 0, 3'b010, 32'h101, 32'd0, 0, 0, 32'd0, -1);
        settle();
        check("lw_misalign", {31'd0, obs_mis}, 32'd1);
        do_txn(1, 0, 3'b001, 32'h103, 32'd0, 0, 0, 32'd0, -1);
        settle();
        check("lh_misalign", {31'd0, obs_mis}, 32'd1);

`ifndef LSU_TIMEOUT_EN
        // gnt 3 cycles late, rvalid 2 cycles after gnt
        do_txn(1, 0, 3'b010, 32'h200, 32'd0, 3, 1, 32'h0BAD_F00D, -1);
        settle();
        check("lw_slow_stall_cycles", last_stall_run, 7);
        check("lw_slow_data", obs_rd, 32'h0BAD_F00D);
`endif

        // reset during WAIT, then stale rvalid must be ignored
        do_txn(1, 0, 3'b010, 32'h300, 32'd0, 0, 3, 32'h1234_5678, 2);
        idle_cycle(1'b1, 1'b1);
        idle_cycle(1'b0, 1'b1);
        idle_cycle(1'b0, 1'b1);

`ifdef LSU_TIMEOUT_EN
        do_timeout(32'h400);
        settle();
        check("timeout_buserr", {31'd0, obs_buserr}, 32'd1);
        check("timeout_rdata", obs_rd, 32'd0);
        idle_cycle(1'b0, 1'b0);
`endif

        // randomized traffic
        for (int t = 0; t < 200; t++) begin
            sel = int'($urandom_range(0, 9));
            rd = 1'($urandom); wr = 1'($urandom);
            if (sel == 0) begin
                rd = 1'b0; wr = 1'b0;
            end else if (!rd && !wr) rd = 1'b1;
            if (sel <= 7) f3 = valid_f3[$urandom_range(0, 4)];
            else          f3 = 3'($urandom);
            do_txn(rd, wr, f3, $urandom, $urandom,
                   int'($urandom_range(0, c_MAX_G)), int'($urandom_range(0, c_MAX_R)),
                   $urandom, -1);
            if ($urandom_range(0, 3) == 0) idle_cycle(1'b0, 1'($urandom));
        end

        idle_cycle(1'b0, 1'b0);
        settle();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
